// File: rtl/weight_bank_loader_pkg.sv
// Shared definitions for the weight bank loader.
//   state_e            : loader FSM state encoding
//   Def* localparams   : default geometry of the weight banks
package weight_bank_loader_pkg;

   localparam int unsigned DefAddrWidth = 11;
   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefNumBanks  = 4;
   localparam int unsigned DefLayerW    = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StFlush = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/weight_bank_loader.sv
// Streams a layer's weight bytes from the host into NUM_BANKS weight banks. Byte k is
// written to bank k % NUM_BANKS at address k / NUM_BANKS.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   load_start_i           : pulse, start loading layer layer_id_i of layer_len_i words/bank
//   load_abort_i           : pulse, abandon the current load
//   layer_id_i/layer_len_i : sampled on an accepted load_start_i
//   s_valid_i/s_data_i     : host byte stream, s_ready_o is the handshake back
//   wr_en_o                : one-hot bank write enable
//   wr_addr_o/wr_data_o    : shared bank address / data
//   bank_csen_o, busy_o    : high while loading or flushing
//   layer2weight_cnt_o     : latched layer index
//   done_o                 : one-cycle pulse once the final write has been issued
module weight_bank_loader
   import weight_bank_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned NUM_BANKS  = DefNumBanks,
   parameter int unsigned LAYER_W    = DefLayerW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start_i,
   input  logic                  load_abort_i,
   input  logic [LAYER_W-1:0]    layer_id_i,
   input  logic [ADDR_WIDTH:0]   layer_len_i,
   input  logic                  s_valid_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  s_ready_o,
   output logic [NUM_BANKS-1:0]  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic                  bank_csen_o,
   output logic [LAYER_W-1:0]    layer2weight_cnt_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned BankW = $clog2(NUM_BANKS);
   localparam logic [BankW-1:0]  LastBank = BankW'(NUM_BANKS - 1);
   localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                  state_q;
   logic [BankW-1:0]        bank_q;
   logic [ADDR_WIDTH:0]     addr_q;
   logic [ADDR_WIDTH:0]     len_q;
   logic                    s_ready_q;
   logic [NUM_BANKS-1:0]    wr_en_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic [DATA_WIDTH-1:0]   wr_data_q;
   logic                    active_q;
   logic [LAYER_W-1:0]      layer_q;
   logic                    done_q;

   logic [ADDR_WIDTH:0]     len_sat;
   logic [NUM_BANKS-1:0]    bank_onehot;
   logic                    last_beat;

   always_comb begin
      // Longer layers than the banks can hold are clipped to the full bank depth.
      len_sat     = (layer_len_i > MaxLen) ? MaxLen : layer_len_i;
      bank_onehot = NUM_BANKS'(1) << bank_q;
      // len_q is never 0 in LOAD, so len_q - 1 cannot underflow there.
      last_beat   = (addr_q == (len_q - 1'b1)) && (bank_q == LastBank);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         bank_q    <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         s_ready_q <= 1'b0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         active_q  <= 1'b0;
         layer_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         wr_en_q <= '0;
         done_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // A start in the same cycle as an abort wins; abort has no meaning in IDLE.
               if (load_start_i) begin
                  layer_q <= layer_id_i;
                  len_q   <= len_sat;
                  bank_q  <= '0;
                  addr_q  <= '0;
                  if (layer_len_i == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= StLoad;
                     s_ready_q <= 1'b1;
                     active_q  <= 1'b1;
                  end
               end
            end
            StLoad: begin
               // Abort beats a same-cycle transfer: the byte is dropped.
               if (load_abort_i) begin
                  state_q   <= StIdle;
                  s_ready_q <= 1'b0;
                  active_q  <= 1'b0;
               end else if (s_valid_i) begin
                  wr_en_q   <= bank_onehot;
                  wr_addr_q <= addr_q[ADDR_WIDTH-1:0];
                  wr_data_q <= s_data_i;
                  if (last_beat) begin
                     state_q   <= StFlush;
                     s_ready_q <= 1'b0;
                  end else if (bank_q == LastBank) begin
                     bank_q <= '0;
                     addr_q <= addr_q + 1'b1;
                  end else begin
                     bank_q <= bank_q + 1'b1;
                  end
               end
            end
            StFlush: begin
               // Final write is on the bus this cycle.
               active_q <= 1'b0;
               if (load_abort_i) begin
                  state_q <= StIdle;
               end else begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q   <= StIdle;
               s_ready_q <= 1'b0;
               active_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready_o          = s_ready_q;
   assign wr_en_o            = wr_en_q;
   assign wr_addr_o          = wr_addr_q;
   assign wr_data_o          = wr_data_q;
   assign bank_csen_o        = active_q;
   assign busy_o             = active_q;
   assign layer2weight_cnt_o = layer_q;
   assign done_o             = done_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Directed bench for weight_bank_loader: table-driven striping check plus hand-written
// sequences for valid gaps, zero length, abort, reset mid-load, ignored restart and
// length saturation.
module tb_weight_bank_loader;

   localparam int unsigned AW = 11;
   localparam int unsigned DW = 8;
   localparam int unsigned NB = 4;
   localparam int unsigned LW = 4;

   logic          clk;
   logic          rst;
   logic          load_start;
   logic          load_abort;
   logic [LW-1:0] layer_id;
   logic [AW:0]   layer_len;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic [NB-1:0] wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          bank_csen;
   logic [LW-1:0] layer_cnt;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;

   weight_bank_loader #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .NUM_BANKS (NB),
      .LAYER_W   (LW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .load_start_i      (load_start),
      .load_abort_i      (load_abort),
      .layer_id_i        (layer_id),
      .layer_len_i       (layer_len),
      .s_valid_i         (s_valid),
      .s_data_i          (s_data),
      .s_ready_o         (s_ready),
      .wr_en_o           (wr_en),
      .wr_addr_o         (wr_addr),
      .wr_data_o         (wr_data),
      .bank_csen_o       (bank_csen),
      .layer2weight_cnt_o(layer_cnt),
      .busy_o            (busy),
      .done_o            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [NB-1:0] exp_en;
      logic [AW-1:0] exp_addr;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
      if (wr_en != '0) wr_cnt++;
   endtask

   task automatic start(input logic [LW-1:0] id, input logic [AW:0] len);
      load_start = 1'b1;
      layer_id   = id;
      layer_len  = len;
      step();
      load_start = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] last_addr;
      logic [DW-1:0] last_data;
      logic [NB-1:0] last_en;
      int            bank_m;
      logic          saw_done;
      logic          saw_busy;
      logic          finished;

      rst        = 1'b1;
      load_start = 1'b0;
      load_abort = 1'b0;
      layer_id   = '0;
      layer_len  = '0;
      s_valid    = 1'b0;
      s_data     = '0;

      for (int i = 0; i < 8; i++) begin
         vecs[i].data     = DW'(8'h10 + i);
         vecs[i].exp_en   = NB'(1) << (i % 4);
         vecs[i].exp_addr = AW'(i / 4);
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'({s_ready, wr_en, wr_addr, wr_data, bank_csen, layer_cnt, busy,
                                done}), 32'h0);
      rst = 1'b0;
      step();

      // 1: layer 3, len 2, bytes 0x10..0x17 striped over the banks
      start(4'd3, 12'd2);
      chk("t1_ready", 32'(s_ready), 32'd1);
      chk("t1_busy_csen", 32'({busy, bank_csen}), 32'h3);
      chk("t1_layer", 32'(layer_cnt), 32'd3);
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = vecs[i].data;
         step();
         chk($sformatf("t1_en[%0d]", i), 32'(wr_en), 32'(vecs[i].exp_en));
         chk($sformatf("t1_addr[%0d]", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
         chk($sformatf("t1_data[%0d]", i), 32'(wr_data), 32'(vecs[i].data));
      end
      chk("t1_flush_ready", 32'({s_ready, busy, done}), 32'b010);
      s_valid = 1'b0;
      step();
      chk("t1_done", 32'({done, busy, bank_csen, wr_en}), 32'h40);
      step();
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_layer_held", 32'(layer_cnt), 32'd3);

      // 2: len 1 with s_valid every other cycle; addr/data hold between writes
      start(4'd1, 12'd1);
      bank_m    = 0;
      last_addr = AW'(1);
      last_data = 8'h17;
      for (int i = 0; i < 8; i++) begin
         s_valid = i[0];
         s_data  = DW'(8'h20 + i);
         step();
         if (i[0]) begin
            chk($sformatf("t2_en[%0d]", i), 32'(wr_en), 32'(NB'(1) << bank_m));
            last_addr = '0;
            last_data = DW'(8'h20 + i);
            bank_m++;
         end else begin
            chk($sformatf("t2_en[%0d]", i), 32'(wr_en), 32'h0);
         end
         chk($sformatf("t2_addr[%0d]", i), 32'(wr_addr), 32'(last_addr));
         chk($sformatf("t2_data[%0d]", i), 32'(wr_data), 32'(last_data));
      end
      s_valid = 1'b0;
      step();
      chk("t2_done", 32'(done), 32'd1);
      step();

      // 3: len 0 goes straight to DONE with no writes and never busy
      wr_cnt = 0;
      start(4'd6, 12'd0);
      chk("t3_done", 32'({done, busy, s_ready, wr_en}), 32'h40);
      step();
      chk("t3_done_pulse", 32'({done, busy}), 32'h0);
      chk("t3_layer", 32'(layer_cnt), 32'd6);
      chk("t3_no_writes", 32'(wr_cnt), 32'd0);

      // Start and abort together in IDLE: start wins
      load_abort = 1'b1;
      start(4'd2, 12'd1);
      load_abort = 1'b0;
      chk("start_beats_abort", 32'({busy, s_ready, layer_cnt}), 32'h32);
      load_abort = 1'b1;
      step();
      load_abort = 1'b0;
      chk("abort_idle", 32'({busy, s_ready}), 32'h0);

      // 4: abort after 5 bytes, 6th byte dropped, no done
      start(4'd5, 12'd2);
      wr_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(8'h40 + i);
         step();
      end
      load_abort = 1'b1;
      s_data     = 8'h45;
      step();
      load_abort = 1'b0;
      s_valid    = 1'b0;
      chk("t4_after_abort", 32'({wr_en, s_ready, busy, bank_csen}), 32'h0);
      chk("t4_data_kept", 32'(wr_data), 32'h44);
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         saw_done |= done;
      end
      chk("t4_no_done", 32'(saw_done), 32'd0);
      chk("t4_writes", 32'(wr_cnt), 32'd5);

      // 5: reset mid-load clears outputs at once, restart begins at bank0@0
      start(4'd8, 12'd2);
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(8'h50 + i);
         step();
      end
      s_valid = 1'b0;
      rst     = 1'b1;
      #1;
      chk("t5_async_reset", 32'({s_ready, wr_en, wr_addr, wr_data, bank_csen, layer_cnt, busy,
                                 done}), 32'h0);
      step();
      rst = 1'b0;
      step();
      start(4'd7, 12'd1);

      // 6: load_start during LOAD with a new layer is ignored
      load_start = 1'b1;
      layer_id   = 4'd9;
      s_valid    = 1'b1;
      s_data     = 8'hA5;
      step();
      load_start = 1'b0;
      chk("t5_restart_en", 32'(wr_en), 32'h1);
      chk("t5_restart_addr_data", 32'({wr_addr, wr_data}), 32'h000A5);
      chk("t6_layer_kept", 32'(layer_cnt), 32'd7);
      for (int i = 0; i < 3; i++) begin
         s_data = DW'(8'hA6 + i);
         step();
      end
      s_valid = 1'b0;
      chk("t6_last_write", 32'({wr_en, wr_data}), 32'h8A8);
      step();
      chk("t6_done", 32'({done, layer_cnt}), 32'h17);

      // Oversized length clips to full bank depth: 2048 words per bank
      step();
      wr_cnt    = 0;
      last_addr = '0;
      last_en   = '0;
      finished  = 1'b0;
      saw_busy  = 1'b1;
      start(4'd4, 12'hFFF);
      s_valid = 1'b1;
      s_data  = 8'h3C;
      for (int i = 0; i < 9000 && !finished; i++) begin
         step();
         if (wr_en != '0) begin
            last_addr = wr_addr;
            last_en   = wr_en;
         end
         if (done) finished = 1'b1;
      end
      s_valid = 1'b0;
      chk("sat_done_seen", 32'(finished), 32'd1);
      chk("sat_writes", 32'(wr_cnt), 32'd8192);
      chk("sat_last_write", 32'({last_en, last_addr}), 32'({4'b1000, 11'd2047}));
      step();
      chk("sat_idle", 32'({busy, done, s_ready}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
